imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sequencer that owns the instruction-memory write port and the core's CLEAR input.
- After reset, and on demand, it holds the pipelined core in CLEAR and accepts a program as a valid/ready word stream. It writes each word to consecutive instruction-memory addresses, then drains the pipeline and releases the core.
- Sits between the test/debug host and the rom/main pair. It replaces ad-hoc program loading in benches.

Parameters:
- ADDR_SIZE, 10, instruction-memory word-address width; capacity is 2**ADDR_SIZE words.
- DATA_SIZE, 32, instruction word width.
- FLUSH_CYCLES, 5, cycles CLEAR stays high after the last write; must be ≥ pipeline depth, range 1..255.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle pulse that requests a new program load.
- ld_valid  in  1  host word valid.
- ld_data  in  DATA_SIZE  host instruction word.
- ld_last  in  1  marks the final word of the program; qualified by ld_valid.
- ld_ready  out  1  loader can accept a word this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_waddr  out  ADDR_SIZE  word address to write.
- imem_wdata  out  DATA_SIZE  word to write.
- CLEAR  out  1  held high to keep the core flushed and at PC 0.
- done  out  1  high while the core is running a loaded program.
- error  out  1  high after an overflow, sticky until next load_start.
- word_count  out  ADDR_SIZE+1  number of words written in the last or current load.

Behaviour:
- Reset, sampled when RESET_N=0 at a rising edge. Values:
  - state=IDLE, CLEAR=1, ld_ready=0, imem_we=0.
  - imem_waddr=0, imem_wdata=0, done=0, error=0, word_count=0.
  - Reset mid-load aborts the load. Words already written stay in memory but are not trusted.
- States: IDLE, LOAD, FLUSH, RUN, ERR.
- IDLE:
  - CLEAR=1, ld_ready=0.
  - load_start → LOAD next cycle, with word_count=0 and the address pointer=0.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid && ld_ready. Next cycle: imem_we=1, imem_waddr=pointer, imem_wdata=ld_data. The pointer and word_count then increment, so write latency is 1 cycle and imem outputs are registered.
  - Back-to-back transfers are allowed, sustaining 1 word/cycle.
  - A transfer with ld_last=1 → FLUSH. ld_ready drops the cycle after that transfer.
  - A transfer when word_count == 2**ADDR_SIZE (memory full) and ld_last=0 → ERR. No write is performed and the pointer does not wrap.
  - A transfer of word 2**ADDR_SIZE with ld_last=1 is legal and goes to FLUSH.
  - load_start during LOAD is ignored.
- FLUSH:
  - CLEAR=1, ld_ready=0.
  - Down-counter loaded with FLUSH_CYCLES on entry; → RUN when it reaches 0. FLUSH lasts exactly FLUSH_CYCLES cycles.
- RUN:
  - CLEAR=0, done=1.
  - load_start → LOAD. CLEAR rises and done falls in the same cycle as the state change, so the core is stopped before any write.
- ERR:
  - CLEAR=1, error=1, ld_ready=0.
  - load_start → LOAD and clears error.
- Simultaneous load_start and RESET_N=0: reset wins.
- imem_we is asserted for exactly one cycle per accepted word and never outside LOAD/the cycle after.

Decomposition:
- Shared package (riscv_pkg): loader_state_t enum {IDLE, LOAD, FLUSH, RUN, ERR}; default FLUSH_CYCLES constant.
- One natural sub-module: loader_flush_timer, a loadable down-counter with a zero flag, reusable for other pipeline-drain holds.
- Everything else is a single FSM plus registered write port.

Test Plan:
- Reset and idle: hold RESET_N=0 for 2 cycles, then release.
  → CLEAR=1, done=0, ld_ready=0, imem_we=0, word_count=0. Unchanged after 10 idle cycles.
- Basic load: load_start, then 4 back-to-back words 0x00000093, 0x00100113, 0x002081B3, 0x0000006F, the last with ld_last.
  → imem writes to addr 0..3 with matching data on consecutive cycles, each one cycle after its handshake.
  → word_count=4. CLEAR falls exactly FLUSH_CYCLES=5 cycles after the last write; done=1.
- Stalled host: ld_valid toggles 1,0,0,1,1 (last on the final word).
  → imem_we only on the cycles after handshakes, addresses 0,1,2 with no gaps in addressing.
- Overflow with ADDR_SIZE=3: send 9 words with no ld_last.
  → 8 writes to addr 0..7, then ERR. error=1, CLEAR=1, no 9th write.
  → A following load_start clears error.
- Exact fill with ADDR_SIZE=3: send 8 words, the 8th with ld_last.
  → No error; FLUSH then RUN, word_count=8.
- Reload while running: in RUN, pulse load_start.
  → CLEAR=1 and done=0 in the same cycle LOAD is entered. A 2-word load then rewrites addr 0..1 and returns to RUN.
  → Apply RESET_N=0 mid-load: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    // Default pipeline-drain hold; must cover the core's pipeline depth.
    localparam int unsigned FLUSH_CYCLES_DEFAULT = 5;

    // Width of the drain down-counter (FLUSH_CYCLES is limited to 1..255).
    localparam int unsigned FLUSH_CNT_W = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Host word stream plus instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DATA_SIZE = 32
);

    logic                 ld_valid;
    logic [DATA_SIZE-1:0] ld_data;
    logic                 ld_last;
    logic                 ld_ready;
    logic                 imem_we;
    logic [ADDR_SIZE-1:0] imem_waddr;
    logic [DATA_SIZE-1:0] imem_wdata;

    // Host side: drives the word stream, observes ready and the memory writes.
    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_we, imem_waddr, imem_wdata
    );

    // Loader side: consumes the word stream, owns the memory write port.
    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_flush_timer.sv
// Loadable down-counter with a zero flag, used to hold a pipeline in drain.
module imem_loader_flush_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/imem_loader.sv
// Program loader: holds the core in CLEAR, streams words into instruction
// memory, drains the pipeline, then releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = 10,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               load_start,
    imem_loader_if.slave       ld,
    output logic               CLEAR,
    output logic               done,
    output logic               error,
    output logic [ADDR_SIZE:0] word_count
);

    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    // The timer is loaded with one less than the hold because the first
    // FLUSH cycle is already spent when the count is visible.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD_VAL = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    loader_state_t        r_state;
    loader_state_t        w_state_nxt;

    logic                 r_ld_ready;
    logic                 r_clear;
    logic                 r_done;
    logic                 r_error;
    logic                 r_we;
    logic [ADDR_SIZE-1:0] r_waddr;
    logic [DATA_SIZE-1:0] r_wdata;
    logic [CNT_W-1:0]     r_word_count;

    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_we_nxt;
    logic                 w_tmr_load;
    logic                 w_tmr_zero;
    logic                 w_xfer;
    logic                 w_full;

    assign w_xfer = ld.ld_valid && r_ld_ready;
    // word_count doubles as the write pointer; its top bit marks a full memory.
    assign w_full = r_word_count[ADDR_SIZE];

    imem_loader_flush_timer #(
        .CNT_W (FLUSH_CNT_W)
    ) u_flush_timer (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_load     (w_tmr_load),
        .i_load_val (FLUSH_LOAD_VAL),
        .o_zero_c   (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, write-enable and counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_word_count;
        w_we_nxt    = 1'b0;
        w_tmr_load  = 1'b0;
        case (r_state)
            IDLE, RUN, ERR: begin
                if (load_start) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    // Any word offered once memory is full is an overflow;
                    // the pointer never wraps onto words already written.
                    if (w_full) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_we_nxt  = 1'b1;
                        w_cnt_nxt = r_word_count + CNT_W'(1);
                        if (ld.ld_last) begin
                            w_state_nxt = FLUSH;
                            w_tmr_load  = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_tmr_zero) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered, so CLEAR/done flip
    // in the same cycle as the state change.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_ld_ready   <= 1'b0;
            r_clear      <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_word_count <= '0;
        end else begin
            r_ld_ready   <= (w_state_nxt == LOAD);
            r_clear      <= (w_state_nxt != RUN);
            r_done       <= (w_state_nxt == RUN);
            r_error      <= (w_state_nxt == ERR);
            r_we         <= w_we_nxt;
            r_word_count <= w_cnt_nxt;
            if (w_we_nxt) begin
                r_waddr <= r_word_count[ADDR_SIZE-1:0];
                r_wdata <= ld.ld_data;
            end
        end
    end

    assign ld.ld_ready   = r_ld_ready;
    assign ld.imem_we    = r_we;
    assign ld.imem_waddr = r_waddr;
    assign ld.imem_wdata = r_wdata;
    assign CLEAR         = r_clear;
    assign done          = r_done;
    assign error         = r_error;
    assign word_count    = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an 8-word memory and a 5-cycle drain.
module tb_imem_loader;

    localparam int unsigned A  = 3;
    localparam int unsigned D  = 32;
    localparam int unsigned FC = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start;
    logic         clear;
    logic         done;
    logic         error;
    logic [A:0]   word_count;

    int tests = 0;
    int fails = 0;

    imem_loader_if #(.ADDR_SIZE(A), .DATA_SIZE(D)) u_if ();

    imem_loader #(
        .ADDR_SIZE    (A),
        .DATA_SIZE    (D),
        .FLUSH_CYCLES (FC)
    ) u_dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .load_start (load_start),
        .ld         (u_if),
        .CLEAR      (clear),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // One cycle: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic         ls;
        logic         v;
        logic [D-1:0] d;
        logic         last;
        logic         e_we;
        logic [A-1:0] e_addr;
        logic [D-1:0] e_data;
        logic         e_rdy;
        logic         e_clr;
        logic         e_done;
        logic         e_err;
        logic [A:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ls, input logic v, input logic [D-1:0] d,
                                input logic last, input logic e_we, input logic [A-1:0] e_addr,
                                input logic [D-1:0] e_data, input logic e_rdy, input logic e_clr,
                                input logic e_done, input logic e_err, input logic [A:0] e_cnt);
        vec_t x;
        x.ls = ls; x.v = v; x.d = d; x.last = last;
        x.e_we = e_we; x.e_addr = e_addr; x.e_data = e_data; x.e_rdy = e_rdy;
        x.e_clr = e_clr; x.e_done = e_done; x.e_err = e_err; x.e_cnt = e_cnt;
        vecs.push_back(x);
    endfunction

    function automatic void idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endfunction

    function automatic void start();
        add(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    endfunction

    function automatic void word(input logic [D-1:0] d, input logic last, input logic [A-1:0] a,
                                 input logic ls);
        add(ls, 1'b1, d, last, 1'b1, a, d, !last, 1'b1, 1'b0, 1'b0, (A+1)'(a) + (A+1)'(1));
    endfunction

    function automatic void gap(input logic [A:0] cnt);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, cnt);
    endfunction

    // Remaining FC-1 drain cycles after the last write, then the core runs.
    function automatic void flush(input logic [A:0] cnt);
        for (int i = 0; i < int'(FC) - 1; i++)
            add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, cnt);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
    endfunction

    task automatic check(input string nm, input bit exact, input logic e_we, input logic [A-1:0] e_addr,
                         input logic [D-1:0] e_data, input logic e_rdy, input logic e_clr,
                         input logic e_done, input logic e_err, input logic [A:0] e_cnt);
        logic ok;
        ok = (u_if.imem_we === e_we) && (u_if.ld_ready === e_rdy) && (clear === e_clr) &&
             (done === e_done) && (error === e_err) && (word_count === e_cnt);
        if (exact || e_we)
            ok = ok && (u_if.imem_waddr === e_addr) && (u_if.imem_wdata === e_data);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got we=%b addr=%0d data=%h rdy=%b clr=%b done=%b err=%b cnt=%0d; want we=%b addr=%0d data=%h rdy=%b clr=%b done=%b err=%b cnt=%0d",
                     nm, u_if.imem_we, u_if.imem_waddr, u_if.imem_wdata, u_if.ld_ready, clear, done,
                     error, word_count, e_we, e_addr, e_data, e_rdy, e_clr, e_done, e_err, e_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string nm);
        check(nm, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int n;

        // Reset and idle, with a stray valid word that must be ignored.
        idle(10);
        add(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Basic back-to-back load of four words.
        start();
        word(32'h00000093, 1'b0, 3'd0, 1'b0);
        word(32'h00100113, 1'b0, 3'd1, 1'b0);
        word(32'h002081B3, 1'b0, 3'd2, 1'b0);
        word(32'h0000006F, 1'b1, 3'd3, 1'b0);
        flush(4'd4);

        // Reload from RUN with a stalling host: valid 1,0,0,1,1.
        start();
        word(32'hA0000000, 1'b0, 3'd0, 1'b0);
        gap(4'd1);
        gap(4'd1);
        word(32'hA0000001, 1'b0, 3'd1, 1'b0);
        word(32'hA0000002, 1'b1, 3'd2, 1'b0);
        flush(4'd3);

        // Exact fill of all 8 words; load_start mid-load is ignored.
        start();
        for (int i = 0; i < 8; i++)
            word(32'h10000000 + 32'(i), (i == 7), A'(i), (i == 3));
        flush(4'd8);

        // Overflow: nine words without last.
        start();
        for (int i = 0; i < 8; i++)
            word(32'h20000000 + 32'(i), 1'b0, A'(i), 1'b0);
        add(1'b0, 1'b1, 32'h20000008, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
        add(1'b0, 1'b1, 32'h20000009, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8);

        // load_start clears the error; a short load rewrites addr 0..1.
        start();
        word(32'h30000000, 1'b0, 3'd0, 1'b0);
        word(32'h30000001, 1'b1, 3'd1, 1'b0);
        flush(4'd2);

        rst_n = 1'b0;
        load_start = 1'b0;
        u_if.ld_valid = 1'b0;
        u_if.ld_data = '0;
        u_if.ld_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            load_start    = vecs[i].ls;
            u_if.ld_valid = vecs[i].v;
            u_if.ld_data  = vecs[i].d;
            u_if.ld_last  = vecs[i].last;
            step();
            check($sformatf("vec%0d", i), 1'b0, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                  vecs[i].e_rdy, vecs[i].e_clr, vecs[i].e_done, vecs[i].e_err, vecs[i].e_cnt);
        end

        // Reload from RUN, one word in, then reset mid-load.
        load_start = 1'b1;
        u_if.ld_valid = 1'b0;
        step();
        check("reload_enter", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        load_start = 1'b0;
        u_if.ld_valid = 1'b1;
        u_if.ld_data = 32'hCAFE0001;
        u_if.ld_last = 1'b0;
        step();
        check("reload_w0", 1'b0, 1'b1, 3'd0, 32'hCAFE0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        rst_n = 1'b0;
        u_if.ld_data = 32'hCAFE0002;
        step();
        check_reset_values("reset_midload");
        rst_n = 1'b1;
        u_if.ld_valid = 1'b0;
        step();
        check_reset_values("idle_after_reset");

        // Reset wins over a simultaneous load_start.
        rst_n = 1'b0;
        load_start = 1'b1;
        step();
        check_reset_values("reset_vs_start");
        rst_n = 1'b1;
        load_start = 1'b0;
        step();
        check_reset_values("start_absorbed");

        // Drain length measured from the last write cycle, bounded wait.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        u_if.ld_valid = 1'b1;
        u_if.ld_data = 32'h40000000;
        step();
        u_if.ld_data = 32'h40000001;
        u_if.ld_last = 1'b1;
        step();
        u_if.ld_valid = 1'b0;
        u_if.ld_last = 1'b0;
        check("drain_last_write", 1'b0, 1'b1, 3'd1, 32'h40000001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (n != int'(FC) || clear !== 1'b0) begin
            fails++;
            $display("FAIL drain_len: got %0d cycles clr=%b; want %0d cycles clr=0", n, clear, FC);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
